debounced_edge_detector: RTL and testbench

Multi-channel successor to the single-bit edge detector. Each channel has a synchroniser, a debounce filter and a registered edge detector, plus a sticky pending flag that software or logic clears. Used on asynchronous inputs such as buttons, panel switches and external strobes, ahead of any logic that acts on their edges.

---
 rtl/edge_pkg.sv | 24 ++
 rtl/debounced_edge_detector_if.sv | 24 ++
 rtl/debounce_channel.sv | 64 ++++++
 rtl/debounced_edge_detector.sv | 58 +++++
 tb/tb_debounced_edge_detector.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/edge_pkg.sv
// Shared constants and helpers for the debounced edge detector:
// pending-event selection modes and the event-select function.
package edge_pkg;

  typedef logic [1:0] pending_mode_t;

  localparam pending_mode_t PENDING_ANY  = 2'd0;
  localparam pending_mode_t PENDING_RISE = 2'd1;
  localparam pending_mode_t PENDING_FALL = 2'd2;

  // Out-of-range modes select nothing, so pending is never set.
  function automatic logic pending_event(pending_mode_t mode, logic pos, logic neg);
    logic ev;
    ev = 1'b0;
    case (mode)
      PENDING_ANY:  ev = pos | neg;
      PENDING_RISE: ev = pos;
      PENDING_FALL: ev = neg;
      default:      ev = 1'b0;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/debounced_edge_detector_if.sv
// Signal bundle between the debounced edge detector and its user logic.
// No handshake: level is asynchronous and clear is a level-sensitive request sampled on clk.
interface debounced_edge_detector_if #(
  parameter int CHANNELS = 8
);
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] clear;
  logic [CHANNELS-1:0] stable;
  logic [CHANNELS-1:0] pos_edge;
  logic [CHANNELS-1:0] neg_edge;
  logic [CHANNELS-1:0] any_edge;
  logic [CHANNELS-1:0] pending;
  logic                irq;

  modport master (
    output level, clear,
    input  stable, pos_edge, neg_edge, any_edge, pending, irq
  );

  modport slave (
    input  level, clear,
    output stable, pos_edge, neg_edge, any_edge, pending, irq
  );
endinterface

// File: rtl/debounce_channel.sv
// One input channel: synchroniser chain, persistence counter, debounced level
// and registered one-cycle edge pulses.
module debounce_channel #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset_low,
  input  logic level,
  output logic stable,
  output logic pos_edge,
  output logic neg_edge
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   stable_q;
  logic                   pos_q;
  logic                   neg_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], level};
    end
  end

  // The count restarts whenever synced agrees with stable, so any glitch
  // shorter than DEBOUNCE_CYCLES leaves no residue behind.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      cnt_q    <= '0;
      stable_q <= RESET_LEVEL;
      pos_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      pos_q <= 1'b0;
      neg_q <= 1'b0;
      if (synced == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q    <= '0;
        stable_q <= synced;
        pos_q    <= synced;
        neg_q    <= ~synced;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign stable   = stable_q;
  assign pos_edge = pos_q;
  assign neg_edge = neg_q;

endmodule

// File: rtl/debounced_edge_detector.sv
// Multi-channel debounced edge detector: per-channel debounce filters plus
// sticky pending flags with per-channel clear and an OR-reduced interrupt.
module debounced_edge_detector
  import edge_pkg::*;
#(
  parameter int            CHANNELS        = 8,
  parameter int            SYNC_STAGES     = 2,
  parameter int            DEBOUNCE_CYCLES = 16,
  parameter logic          RESET_LEVEL     = 1'b0,
  parameter pending_mode_t PENDING_MODE    = PENDING_ANY
) (
  input  logic                      clk,
  input  logic                      reset_low,
  debounced_edge_detector_if.slave  bus
);

  logic [CHANNELS-1:0] stable_w;
  logic [CHANNELS-1:0] pos_w;
  logic [CHANNELS-1:0] neg_w;
  logic [CHANNELS-1:0] set_w;
  logic [CHANNELS-1:0] pending_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL)
    ) u_channel (
      .clk       (clk),
      .reset_low (reset_low),
      .level     (bus.level[g]),
      .stable    (stable_w[g]),
      .pos_edge  (pos_w[g]),
      .neg_edge  (neg_w[g])
    );

    assign set_w[g] = pending_event(PENDING_MODE, pos_w[g], neg_w[g]);
  end

  // A set in the same cycle as a clear wins, so no event is lost.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      pending_q <= '0;
    end else begin
      pending_q <= set_w | (pending_q & ~bus.clear);
    end
  end

  assign bus.stable   = stable_w;
  assign bus.pos_edge = pos_w;
  assign bus.neg_edge = neg_w;
  assign bus.any_edge = pos_w | neg_w;
  assign bus.pending  = pending_q;
  assign bus.irq      = |pending_q;

  a_pending_mode_valid: assert property (@(posedge clk) PENDING_MODE <= PENDING_FALL);

endmodule

// File: tb/tb_debounced_edge_detector.sv
// Bench for debounced_edge_detector: directed scenarios plus randomized levels
// and clears, checked every cycle against a window-based reference model.
module tb_debounced_edge_detector;
  import edge_pkg::*;

  localparam int CH = 8;
  localparam int SS = 2;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic reset_low = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  debounced_edge_detector_if #(.CHANNELS(CH)) bus_a ();
  debounced_edge_detector_if #(.CHANNELS(CH)) bus_r ();

  assign bus_r.level = bus_a.level;
  assign bus_r.clear = bus_a.clear;

  debounced_edge_detector #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
    .RESET_LEVEL(1'b0), .PENDING_MODE(PENDING_ANY)
  ) dut (.clk(clk), .reset_low(reset_low), .bus(bus_a));

  debounced_edge_detector #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
    .RESET_LEVEL(1'b0), .PENDING_MODE(PENDING_RISE)
  ) dut_r (.clk(clk), .reset_low(reset_low), .bus(bus_r));

  // Reference model: history of sampled levels; a channel's level is accepted
  // once the DC synchronised samples in the window all differ from stable.
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_stable, m_pos, m_neg, m_pend_a, m_pend_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    hist = {};
    for (int i = 0; i < SS + DC; i++) hist.push_back('0);
    m_stable = '0; m_pos = '0; m_neg = '0; m_pend_a = '0; m_pend_r = '0;
  endfunction

  function automatic void model_step(input logic [CH-1:0] lv, input logic [CH-1:0] clr);
    logic all_diff;
    m_pend_a = (m_pos | m_neg) | (m_pend_a & ~clr);
    m_pend_r = m_pos | (m_pend_r & ~clr);
    hist.push_back(lv);
    if (hist.size() > SS + DC) void'(hist.pop_front());
    m_pos = '0;
    m_neg = '0;
    for (int c = 0; c < CH; c++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DC; j++) if (hist[j][c] == m_stable[c]) all_diff = 1'b0;
      if (all_diff) begin
        m_stable[c] = ~m_stable[c];
        m_pos[c]    = m_stable[c];
        m_neg[c]    = ~m_stable[c];
      end
    end
  endfunction

  task automatic compare_all();
    check("stable",   bus_a.stable,   m_stable);
    check("pos_edge", bus_a.pos_edge, m_pos);
    check("neg_edge", bus_a.neg_edge, m_neg);
    check("any_edge", bus_a.any_edge, m_pos | m_neg);
    check("edge_excl", bus_a.pos_edge & bus_a.neg_edge, '0);
    check("pending",  bus_a.pending,  m_pend_a);
    check("irq",      bus_a.irq,      |m_pend_a);
    check("stable_r", bus_r.stable,   m_stable);
    check("pending_r", bus_r.pending, m_pend_r);
    check("irq_r",    bus_r.irq,      |m_pend_r);
  endtask

  // One clock: inputs were set before the edge, outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step(bus_a.level, bus_a.clear);
    compare_all();
  endtask

  // Ticks until the chosen edge bit of channel ch is seen; n = -1 on timeout.
  task automatic wait_edge(input int ch, input bit want_neg, output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if ((want_neg ? bus_a.neg_edge[ch] : bus_a.pos_edge[ch]) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, n2;
    logic [CH-1:0] seen;
    bus_a.level = '0;
    bus_a.clear = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_stable",  bus_a.stable,   '0);
    check("rst_any",     bus_a.any_edge, '0);
    check("rst_pending", bus_a.pending,  '0);
    check("rst_irq",     bus_a.irq,      1'b0);
    @(negedge clk);
    reset_low = 1'b1;

    // Quiet inputs after reset: nothing happens.
    seen = '0;
    repeat (20) begin tick(); seen |= bus_a.any_edge; end
    check("quiet_edges", seen, '0);
    check("quiet_irq", bus_a.irq, 1'b0);

    // ch0 rises and holds.
    bus_a.level[0] = 1'b1;
    wait_edge(0, 1'b0, n);
    check("ch0_latency", n, 6);
    check("ch0_stable", bus_a.stable[0], 1'b1);
    tick();
    check("ch0_pending", bus_a.pending[0], 1'b1);
    check("ch0_irq", bus_a.irq, 1'b1);

    // ch3 glitch of 3 cycles is rejected, 4-cycle pulse is accepted.
    bus_a.level[3] = 1'b1;
    repeat (3) tick();
    bus_a.level[3] = 1'b0;
    seen = '0;
    repeat (12) begin tick(); seen |= bus_a.any_edge; end
    check("ch3_glitch_edges", seen[3], 1'b0);
    check("ch3_glitch_stable", bus_a.stable[3], 1'b0);
    bus_a.level[3] = 1'b1;
    repeat (4) tick();
    bus_a.level[3] = 1'b0;
    n = -1; n2 = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus_a.pos_edge[3] && n < 0) n = i;
      if (bus_a.neg_edge[3] && n2 < 0) n2 = i;
    end
    check("ch3_pos_seen", (n > 0), 1'b1);
    check("ch3_neg_gap", n2 - n, 4);

    // Clear everything, then ch1 and ch5 toggle together.
    bus_a.clear = '1;
    tick();
    bus_a.clear = '0;
    check("clear_all", bus_a.pending, '0);
    bus_a.level[1] = 1'b1;
    bus_a.level[5] = 1'b1;
    wait_edge(1, 1'b0, n);
    check("ch15_latency", n, 6);
    check("ch15_any", bus_a.any_edge, 8'h22);
    tick();
    check("ch15_pending", bus_a.pending, 8'h22);
    bus_a.clear = 8'h02;
    tick();
    bus_a.clear = '0;
    check("ch1_cleared", bus_a.pending, 8'h20);
    check("ch5_irq", bus_a.irq, 1'b1);

    // Edge on ch2 coincides with clear[2]: set wins.
    bus_a.level[2] = 1'b1;
    wait_edge(2, 1'b0, n);
    check("ch2_latency", n, 6);
    bus_a.clear[2] = 1'b1;
    tick();
    check("ch2_set_wins", bus_a.pending[2], 1'b1);
    tick();
    bus_a.clear[2] = 1'b0;
    check("ch2_cleared", bus_a.pending[2], 1'b0);

    // Falling edge on ch0: rising-only instance does not set pending.
    bus_a.clear = 8'h01;
    tick();
    bus_a.clear = '0;
    bus_a.level[0] = 1'b0;
    wait_edge(0, 1'b1, n);
    check("ch0_fall_latency", n, 6);
    check("ch0_fall_neg_r", bus_r.neg_edge[0], 1'b1);
    tick();
    check("ch0_fall_pend_r", bus_r.pending[0], 1'b0);
    check("ch0_fall_pend_a", bus_a.pending[0], 1'b1);

    // Reset two cycles into a ch4 debounce.
    bus_a.level[4] = 1'b1;
    repeat (2) tick();
    reset_low = 1'b0;
    #1;
    check("mid_rst_stable",  bus_a.stable,   '0);
    check("mid_rst_pending", bus_a.pending,  '0);
    check("mid_rst_irq",     bus_a.irq,      1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_low = 1'b1;
    wait_edge(4, 1'b0, n);
    check("ch4_post_rst_latency", n, 6);

    // Randomized levels and clears against the model.
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) bus_a.level[c] = ~bus_a.level[c];
        bus_a.clear[c] = ($urandom_range(0, 7) == 0);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
